// File: rtl/ff_d_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ff_d_pipe_pkg
// Shared constants for the elastic register pipeline used in the FPU
// datapath: the default word width and the helper that sizes the
// occupancy counter for an S-stage pipe (it must hold 0..S inclusive).
// ---------------------------------------------------------------------------
package ff_d_pipe_pkg;

   // Default datapath word width (single-precision operand).
   localparam int unsigned FF_D_P_DEFAULT = 32;

   // Default pipeline depth.
   localparam int unsigned FF_D_S_DEFAULT = 3;

   // Bits needed to count 0..s valid stages.
   function automatic int unsigned occ_width(input int unsigned s);
      return $clog2(s + 1);
   endfunction

endpackage : ff_d_pipe_pkg

// File: rtl/ff_d_pipe_stage.sv
// ---------------------------------------------------------------------------
// ff_d_stage
// One stage of the elastic pipeline: a P-bit data register and its valid
// bit. The data register only captures when the incoming word is valid, so
// a stage that takes in a bubble keeps its stale data (nobody can see it,
// because the valid bit is low).
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears valid and data
//   flush_i  : synchronous clear of the valid bit, data untouched
//   load_i   : stage takes the predecessor word/valid this cycle
//   valid_i  : predecessor valid bit
//   data_i   : predecessor data word
//   valid_o  : registered valid bit
//   data_o   : registered data word
// ---------------------------------------------------------------------------
module ff_d_stage
   import ff_d_pipe_pkg::*;
#(
   parameter int unsigned P = FF_D_P_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         valid_i,
   input  logic [P-1:0] data_i,
   output logic         valid_o,
   output logic [P-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [P-1:0] data_q,  data_d;

   // Flush wins over load; the caller already folds the global enable
   // into load_i.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : ff_d_stage

// File: rtl/ff_d_pipe.sv
// ---------------------------------------------------------------------------
// ff_d_pipe
// Stallable S-stage, P-bit delay line with valid/ready flow control.
// Empty stages always pull from their predecessor so bubbles collapse
// toward the output. The ready chain is purely combinational from
// OUT_READY back to IN_READY (no skid buffer).
//
// Ports
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset (valid, data, occupancy -> 0)
//   EN        : global enable; low freezes state and blocks handshakes
//   FLUSH     : synchronous clear of all valid bits and the occupancy
//   IN_VALID  : D carries a word
//   IN_READY  : pipe accepts D this cycle
//   D         : input word
//   OUT_VALID : Q carries a valid word
//   OUT_READY : downstream takes Q this cycle
//   Q         : last-stage data register (driven regardless of valid)
//   OCC       : number of valid stages, 0..S
// ---------------------------------------------------------------------------
module ff_d_pipe
   import ff_d_pipe_pkg::*;
#(
   parameter  int unsigned P  = FF_D_P_DEFAULT,
   parameter  int unsigned S  = FF_D_S_DEFAULT,
   localparam int unsigned OW = occ_width(S)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          FLUSH,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [P-1:0]  D,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [P-1:0]  Q,
   output logic [OW-1:0] OCC
);

   logic [S-1:0][P-1:0] data_q;
   logic [S-1:0]        v_q;
   logic [S-1:0][P-1:0] d_in;
   logic [S-1:0]        v_in;
   logic [S-1:0]        rdy;
   logic [S-1:0]        load;
   logic [OW-1:0]       occ_q, occ_d;
   logic                accept;
   logic                emit;

   // Ready chain: a stage can take a new word if it is empty or if the
   // stage after it is moving. Computed output-first in one process.
   always_comb begin
      rdy        = '0;
      rdy[S-1]   = ~v_q[S-1] | OUT_READY;
      for (int i = int'(S) - 2; i >= 0; i--) begin
         rdy[i] = ~v_q[i] | rdy[i+1];
      end
   end

   for (genvar i = 0; i < S; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign d_in[i] = D;
         assign v_in[i] = IN_VALID;
      end else begin : g_body
         assign d_in[i] = data_q[i-1];
         assign v_in[i] = v_q[i-1];
      end

      assign load[i] = EN & rdy[i];

      ff_d_stage #(
         .P (P)
      ) u_stage (
         .clk_i   (CLK),
         .rst_i   (RST),
         .flush_i (FLUSH),
         .load_i  (load[i]),
         .valid_i (v_in[i]),
         .data_i  (d_in[i]),
         .valid_o (v_q[i]),
         .data_o  (data_q[i])
      );
   end

   assign IN_READY  = EN & ~FLUSH & rdy[0];
   assign OUT_VALID = EN & v_q[S-1];
   assign Q         = data_q[S-1];

   // A word sitting at the output during a flush is dropped, not emitted.
   assign accept = IN_VALID & IN_READY;
   assign emit   = OUT_VALID & OUT_READY & ~FLUSH;

   always_comb begin
      occ_d = occ_q;
      if (FLUSH) begin
         occ_d = '0;
      end else if (EN) begin
         occ_d = occ_q + OW'(accept) - OW'(emit);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign OCC = occ_q;

endmodule : ff_d_pipe
